if_prefetch_queue: RTL and testbench

- Instruction prefetch stage between the instruction-memory SRAM wrapper and the CPU fetch/decode boundary.
- Issues sequential word reads to IM, buffers returned instructions with their PCs in a small FIFO, and presents them to the CPU over a valid/ready handshake.
- On a control-flow redirect it kills in-flight reads, flushes the FIFO and restarts fetch at the new PC.

---
 rtl/if_prefetch_queue_pkg.sv | 22 ++
 rtl/if_prefetch_queue_fifo.sv | 73 +++++++
 rtl/if_prefetch_queue.sv | 196 +++++++++++++++++++
 tb/tb_if_prefetch_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg - shared types and constants for the instruction prefetch queue.
//   fetch_entry_t : one buffered instruction word together with its PC
//   pfq_state_t   : fetch control states (boot / run / halt)
//   IM_AW         : instruction-memory word-address width
// ---------------------------------------------------------------------------
package if_pkg;

  localparam int IM_AW = 14;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } pfq_state_t;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// pfq_fifo - small first-word-fall-through FIFO of fetch_entry_t.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointers and count)
//   push      : write wr_data at the tail this cycle
//   pop       : drop the head this cycle (caller guarantees !empty)
//   flush     : empty the FIFO; overrides push and pop
//   wr_data   : entry to write
//   rd_data   : current head entry (combinational read)
//   count     : number of stored entries, 0..DEPTH
//   full/empty: status flags derived from count
// ---------------------------------------------------------------------------
module pfq_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wr_data,
  output fetch_entry_t               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue - instruction prefetch stage.
// Issues sequential word reads to instruction memory, buffers the returned
// words with their PCs and hands them to the CPU over valid/ready. A redirect
// kills in-flight reads, flushes the buffer and restarts fetch at the new PC.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   im_en, im_addr  : IM read request (word address = fetch_pc[15:2])
//   im_rdata        : IM read data, valid IM_LAT cycles after the request
//   fetch_halt      : level; stops new requests while high
//   redirect_valid  : one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc     : new PC, low two bits ignored
//   instr_valid/instr_ready/instr_out/instr_pc : CPU-side handshake
// Build option:
//   PFQ_BYPASS_EN   : when defined, a response arriving at an empty buffer is
//                     presented in the same cycle (latency IM_LAT instead of
//                     IM_LAT+1) and only written if the CPU does not take it.
// ---------------------------------------------------------------------------
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          IM_LAT   = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_en,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  input  logic             fetch_halt,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr_out,
  output logic [31:0]      instr_pc
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(DEPTH);

  pfq_state_t    state_reg;
  logic [31:0]   fetch_pc_reg;
  logic          redirect_eff;
  logic          issue;
  logic [IM_LAT-1:0] stage_valid;
  logic [31:0]   stage_pc [IM_LAT];
  logic [AW:0]   inflight;
  logic [AW:0]   fifo_count;
  logic [AW+1:0] occupancy;
  logic          live;
  logic          bypass;
  fetch_entry_t  resp;
  fetch_entry_t  fifo_head;
  fetch_entry_t  shown;
  fetch_entry_t  hold_reg;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  // A redirect during the boot cycle is ignored; nothing is in flight then.
  assign redirect_eff = redirect_valid && (state_reg != S_BOOT);

  // Credit check counts queued plus requested-but-not-returned words. Pops in
  // the same cycle are deliberately not credited, keeping the path short.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue     = (state_reg == S_RUN) && !redirect_valid && (occupancy < DEPTH_OCC);

  assign im_en   = issue;
  assign im_addr = fetch_pc_reg[IM_AW+1:2];

  // In-flight pipe: stage 0 is the request just issued, the last stage lines
  // up with im_rdata.
  genvar gi;
  generate
    for (gi = 0; gi < IM_LAT; gi++) begin : g_stage
      logic        v_reg;
      logic [31:0] pc_reg;
      logic        v_next;
      logic [31:0] pc_next;
      if (gi == 0) begin : g_first
        assign v_next  = issue;
        assign pc_next = fetch_pc_reg;
      end else begin : g_rest
        assign v_next  = stage_valid[gi-1];
        assign pc_next = stage_pc[gi-1];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg  <= 1'b0;
          pc_reg <= '0;
        end else begin
          v_reg  <= v_next && !redirect_eff;
          pc_reg <= pc_next;
        end
      end
      assign stage_valid[gi] = v_reg;
      assign stage_pc[gi]    = pc_reg;
    end
  endgenerate

  always_comb begin
    inflight = '0;
    for (int i = 0; i < IM_LAT; i++) begin
      inflight = inflight + (AW+1)'(stage_valid[i]);
    end
  end

  // A response landing in the redirect cycle belongs to the old stream.
  assign live = stage_valid[IM_LAT-1] && !redirect_eff;
  assign resp = '{instr: im_rdata, pc: stage_pc[IM_LAT-1]};

`ifdef PFQ_BYPASS_EN
  assign bypass = live && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // Head selection: buffered entry first, then a bypassed response; when
  // nothing is available the last presented entry is held on the outputs.
  always_comb begin
    shown = hold_reg;
    if (!fifo_empty) begin
      shown = fifo_head;
    end else if (bypass) begin
      shown = resp;
    end
  end

  assign instr_valid = !fifo_empty || bypass;
  assign instr_out   = shown.instr;
  assign instr_pc    = shown.pc;

  assign fifo_pop  = !fifo_empty && instr_ready;
  assign fifo_push = live && !(bypass && instr_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (instr_valid) begin
      hold_reg <= shown;
    end
  end

  pfq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect_eff),
    .wr_data (resp),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_BOOT;
      fetch_pc_reg <= RESET_PC;
    end else begin
      case (state_reg)
        S_BOOT: state_reg <= S_RUN;
        S_RUN: begin
          if (fetch_halt) begin
            state_reg <= S_HALT;
          end
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & ~32'd3;
          end else if (issue) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
          end
        end
        S_HALT: begin
          if (!fetch_halt) begin
            state_reg <= S_RUN;
          end
          if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & ~32'd3;
          end
        end
        default: state_reg <= S_BOOT;
      endcase
    end
  end

  // The credit check makes overflow impossible; this guards that argument.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop && !redirect_eff));

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
  import if_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          IM_LAT   = 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int FIRST = BYPASS ? IM_LAT + 1 : IM_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        im_en;
  logic [13:0] im_addr;
  logic [31:0] im_rdata = '0;
  logic        fetch_halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .IM_LAT   (IM_LAT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .im_en          (im_en),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .fetch_halt     (fetch_halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return 32'hA000_0000 + {18'd0, a};
  endfunction

  // ---------------- instruction memory model ----------------
  logic        env_v [IM_LAT];
  logic [13:0] env_a [IM_LAT];
  logic        cap_v;
  logic [13:0] cap_a;

  initial begin
    for (int i = 0; i < IM_LAT; i++) begin
      env_v[i] = 1'b0;
      env_a[i] = '0;
    end
  end

  always begin
    @(negedge clk);
    cap_v = im_en;
    cap_a = im_addr;
    @(posedge clk);
    #1;
    for (int i = IM_LAT - 1; i > 0; i--) begin
      env_v[i] = env_v[i-1];
      env_a[i] = env_a[i-1];
    end
    env_v[0] = cap_v;
    env_a[0] = cap_a;
    im_rdata = env_v[IM_LAT-1] ? mem_word(env_a[IM_LAT-1]) : $urandom;
  end

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] pc;
    int          due;
  } req_t;

  req_t         m_inflight[$];
  fetch_entry_t m_fifo[$];
  bit           m_boot;
  bit           m_halted;
  logic [31:0]  m_pc;
  fetch_entry_t m_last;
  int           cyc;

  always @(negedge clk) begin : model_proc
    bit exp_en, redir, due_now, live, shown_v, fifo_had;
    fetch_entry_t resp, shown;
    if (rst) begin
      m_inflight.delete();
      m_fifo.delete();
      m_boot   = 1'b1;
      m_halted = 1'b0;
      m_pc     = RESET_PC;
      m_last   = '0;
      cyc      = 0;
      chk("rst_im_en", 32'(im_en), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr_out", instr_out, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
    end else begin
      redir    = redirect_valid && !m_boot;
      exp_en   = !m_boot && !m_halted && !redirect_valid &&
                 (m_fifo.size() + m_inflight.size() < DEPTH);
      due_now  = (m_inflight.size() > 0) && (m_inflight[0].due == cyc);
      resp     = '0;
      if (due_now) begin
        resp.pc    = m_inflight[0].pc;
        resp.instr = mem_word(resp.pc[15:2]);
      end
      live     = due_now && !redir;
      fifo_had = m_fifo.size() > 0;
      shown_v  = 1'b0;
      shown    = m_last;
      if (fifo_had) begin
        shown_v = 1'b1;
        shown   = m_fifo[0];
      end else if (BYPASS && live) begin
        shown_v = 1'b1;
        shown   = resp;
      end

      chk("im_en", 32'(im_en), 32'(exp_en));
      if (exp_en) chk("im_addr", 32'(im_addr), 32'(m_pc[15:2]));
      chk("instr_valid", 32'(instr_valid), 32'(shown_v));
      chk("instr_out", instr_out, shown.instr);
      chk("instr_pc", instr_pc, shown.pc);

      if (shown_v) m_last = shown;
      if (redir) begin
        m_fifo.delete();
        m_inflight.delete();
        m_pc = redirect_pc & ~32'd3;
      end else begin
        if (due_now) void'(m_inflight.pop_front());
        if (fifo_had && instr_ready) void'(m_fifo.pop_front());
        if (live && !(BYPASS && !fifo_had && instr_ready)) m_fifo.push_back(resp);
        if (exp_en) begin
          m_inflight.push_back('{pc: m_pc, due: cyc + IM_LAT});
          m_pc = m_pc + 32'd4;
        end
      end

      if (m_boot) m_boot = 1'b0;
      else if (!m_halted && fetch_halt) m_halted = 1'b1;
      else if (m_halted && !fetch_halt) m_halted = 1'b0;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    fetch_halt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Caller sits 4 time units after a rising edge; ready is expected high.
  task automatic expect_pcs(input string tag, input logic [31:0] base, input int n);
    int got;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      if (instr_valid && instr_ready) begin
        chk(tag, instr_pc, base + 32'(4 * got));
        got++;
      end
      tick();
      #3;
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int n_issue;
    int n_seen;
    int ready_pct;

    #1 rst = 1'b1;

    // Scenario 1: reset release, continuous ready.
    instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < FIRST + 4; c++) begin
      #3;
      if (c == 0) chk("s1_boot_im_en", 32'(im_en), 32'd0);
      if (c == 1) begin
        chk("s1_first_im_en", 32'(im_en), 32'd1);
        chk("s1_first_addr", 32'(im_addr), 32'd0);
      end
      if (c == FIRST - 1) chk("s1_not_yet_valid", 32'(instr_valid), 32'd0);
      if (c >= FIRST) begin
        chk("s1_valid", 32'(instr_valid), 32'd1);
        chk("s1_pc", instr_pc, 32'((c - FIRST) * 4));
        chk("s1_instr", instr_out, 32'hA000_0000 + 32'(c - FIRST));
      end
      tick();
    end

    // Scenario 2: ready low from reset, credits run out, then drain.
    instr_ready = 1'b0;
    do_reset();
    n_issue = 0;
    for (int c = 0; c < 12; c++) begin
      #3;
      if (im_en) n_issue++;
      tick();
    end
    #3;
    chk("s2_issue_count", 32'(n_issue), 32'(DEPTH));
    chk("s2_valid_held", 32'(instr_valid), 32'd1);
    chk("s2_instr_held", instr_out, 32'hA000_0000);
    chk("s2_pc_held", instr_pc, 32'd0);
    tick();
    instr_ready = 1'b1;
    #3;
    expect_pcs("s2_drain_pc", 32'd0, 6);

    // Scenario 3: redirect with buffer partly full and a read in flight.
    instr_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #3;
    chk("s3_head_pc", instr_pc, 32'd0);
    chk("s3_redirect_im_en", 32'(im_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #3;
    chk("s3_flushed_valid", 32'(instr_valid), 32'd0);
    chk("s3_new_im_en", 32'(im_en), 32'd1);
    chk("s3_new_addr", 32'(im_addr), 32'h40);
    expect_pcs("s3_pc", 32'h100, 2);

    // Scenario 4: redirect on a cycle with a transfer and a live response.
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #3;
    chk("s4_head_valid", 32'(instr_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    #3;
    chk("s4_after_valid", 32'(instr_valid), 32'd0);
    expect_pcs("s4_pc", 32'h100, 4);

    // Scenario 5: halt for five cycles mid-stream; delivered PCs stay sequential.
    instr_ready = 1'b1;
    do_reset();
    n_seen = 0;
    for (int c = 0; c < 30; c++) begin
      fetch_halt = (c >= 5 && c < 10);
      #3;
      if (c >= 6 && c < 11) chk("s5_halt_im_en", 32'(im_en), 32'd0);
      if (instr_valid) begin
        chk("s5_seq_pc", instr_pc, 32'(n_seen * 4));
        n_seen++;
      end
      tick();
    end
    fetch_halt = 1'b0;

    // Scenario 6: asynchronous reset mid-stream.
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("s6_async_im_en", 32'(im_en), 32'd0);
    chk("s6_async_valid", 32'(instr_valid), 32'd0);
    chk("s6_async_out", instr_out, 32'd0);
    chk("s6_async_pc", instr_pc, 32'd0);
    tick();
    rst = 1'b0;
    #3;
    expect_pcs("s6_restart_pc", RESET_PC, 3);

    // Randomised phase against the reference model.
    do_reset();
    ready_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) ready_pct = $urandom_range(0, 100);
      instr_ready    = ($urandom_range(1, 100) <= ready_pct);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : $urandom;
      if ($urandom_range(0, 39) == 0) fetch_halt = ~fetch_halt;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    fetch_halt = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
